// File: rtl/snn_seq_pkg.sv
// Shared types and helpers for the SNN batch sequencer.
// Holds the sequencer state encoding and a saturating increment.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CHECK,
    FINISH
  } seq_state_t;

  // Increment v unless it already sits at max_v.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max_v
  );
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/snn_batch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Ports: clk, rst (sync, active-high), clr, en -> cnt (W bits).
module sat_counter
  import snn_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONES = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = W'(sat_inc(32'(cnt_q), 32'(ONES)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/snn_batch_sequencer.sv
// Batch self-test controller for snn_core: steps through the input
// sample banks, runs the core on each and scores the returned digit.
// Ports: go/loop_mode/stop_req control; q_bank/core_addr in and
// ram_addr/core_q out form the sample mux; core_start/core_done/
// core_digit talk to the core; sel, busy, result_valid/result_pass,
// pass_cnt/fail_cnt, timeout_err and batch_done report status.
module snn_batch_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_SAMPLES    = 10,
  localparam int SEL_W         = $clog2(NUM_SAMPLES),
  parameter int ADDR_WIDTH     = 10,
  parameter int DIGIT_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic                   loop_mode,
  input  logic                   stop_req,
  input  logic [DIGIT_WIDTH-1:0] exp_label,
  input  logic [NUM_SAMPLES-1:0] q_bank,
  input  logic [ADDR_WIDTH-1:0]  core_addr,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   core_q,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [DIGIT_WIDTH-1:0] core_digit,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   result_pass,
  output logic [CNT_WIDTH-1:0]   pass_cnt,
  output logic [CNT_WIDTH-1:0]   fail_cnt,
  output logic                   timeout_err,
  output logic                   batch_done
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TO_LAST =
    TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST =
    SEL_W'(NUM_SAMPLES - 1);

  seq_state_t        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;
  logic              start_q, start_d;
  logic              rv_q, rv_d;
  logic              bd_q, bd_d;
  logic              busy_q, busy_d;

  logic cnt_clr;
  logic pass_en;
  logic fail_en;
  logic last;

  assign last = (sel_q == SEL_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    loop_d  = loop_q;
    stop_d  = stop_q;
    tcnt_d  = '0;
    pass_d  = pass_q;
    to_d    = to_q;
    cnt_clr = 1'b0;
    pass_en = 1'b0;
    fail_en = 1'b0;

    if (state_q != IDLE && stop_req) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = START;
          sel_d   = '0;
          loop_d  = loop_mode;
          to_d    = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        // Counter tracks cycles since core_start.
        state_d = WAIT;
        tcnt_d  = TCNT_W'(1);
      end
      WAIT: begin
        if (core_done) begin
          // Digit is scored as it is captured; sel
          // cannot move before CHECK completes.
          state_d = CHECK;
          pass_d  = (core_digit == exp_label);
        end else if (tcnt_q == TO_LAST) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      CHECK: begin
        pass_en = pass_q;
        fail_en = !pass_q;
        if (stop_q || stop_req || (last && !loop_q)) begin
          state_d = FINISH;
        end else begin
          sel_d   = last ? '0 : sel_q + SEL_W'(1);
          state_d = START;
        end
      end
      FINISH: begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    start_d = (state_d == START);
    rv_d    = (state_d == CHECK);
    bd_d    = (state_d == FINISH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      tcnt_q  <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      bd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      tcnt_q  <= tcnt_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      start_q <= start_d;
      rv_q    <= rv_d;
      bd_q    <= bd_d;
      busy_q  <= busy_d;
    end
  end

  sat_counter #(
    .W(CNT_WIDTH)
  ) u_pass_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (pass_en),
    .cnt(pass_cnt)
  );

  sat_counter #(
    .W(CNT_WIDTH)
  ) u_fail_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (fail_en),
    .cnt(fail_cnt)
  );

  assign ram_addr     = core_addr;
  assign core_q       = q_bank[sel_q];
  assign core_start   = start_q;
  assign sel          = sel_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result_pass  = pass_q;
  assign timeout_err  = to_q;
  assign batch_done   = bd_q;

endmodule

// File: tb/tb_snn_batch_sequencer.sv
// Self-checking bench for snn_batch_sequencer.
// Random core latency/labels against a transaction-level model.
module tb_snn_batch_sequencer;

  localparam int N    = 10;
  localparam int AW   = 10;
  localparam int DW   = 4;
  localparam int TO   = 64;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic          loop_mode = 1'b0;
  logic          stop_req = 1'b0;
  logic [DW-1:0] exp_label;
  logic [N-1:0]  q_bank = '0;
  logic [AW-1:0] core_addr = '0;
  logic [AW-1:0] ram_addr;
  logic          core_q;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_digit = '0;
  logic [3:0]    sel;
  logic          busy;
  logic          result_valid;
  logic          result_pass;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic          timeout_err;
  logic          batch_done;

  logic [DW-1:0] label_tab [N];
  logic [N-1:0]  wrong_mask = '0;
  bit            hang = 0;
  int            lat_lo = 1;
  int            lat_hi = 40;
  bit            mon_en = 0;

  int checks = 0;
  int errors = 0;

  // model state
  bit active = 0, loop_l = 0, stop_l = 0, to_e = 0;
  int esel = 0, npass = 0, nfail = 0, nres = 0, wcnt = 0;
  bit c_start = 0, c_rv = 0, c_bd = 0, c_busy = 0, e_pass = 0;
  bit n_start, n_rv, n_bd;
  bit res_log[$];
  int sel_log[$];

  assign exp_label = label_tab[sel];

  always #5 clk = ~clk;

  snn_batch_sequencer #(
    .NUM_SAMPLES   (N),
    .ADDR_WIDTH    (AW),
    .DIGIT_WIDTH   (DW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .loop_mode   (loop_mode),
    .stop_req    (stop_req),
    .exp_label   (exp_label),
    .q_bank      (q_bank),
    .core_addr   (core_addr),
    .ram_addr    (ram_addr),
    .core_q      (core_q),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_digit  (core_digit),
    .sel         (sel),
    .busy        (busy),
    .result_valid(result_valid),
    .result_pass (result_pass),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .timeout_err (timeout_err),
    .batch_done  (batch_done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // random sample RAM data and core address
  initial begin
    forever begin
      @(posedge clk);
      #2;
      q_bank    = N'($urandom);
      core_addr = AW'($urandom);
    end
  end

  // behavioural core: done one cycle, lat cycles after start
  initial begin
    int lat;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (core_start && !hang) begin
        lat = $urandom_range(lat_hi, lat_lo);
        d = label_tab[esel];
        if (wrong_mask[esel]) d = d + DW'(1);
        repeat (lat) @(posedge clk);
        #1;
        core_done  = 1'b1;
        core_digit = d;
        @(posedge clk);
        #1;
        core_done  = 1'b0;
        core_digit = DW'($urandom);
      end
    end
  end

  // compare + model advance, once per cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ram_addr", int'(ram_addr), int'(core_addr));
      chk("core_q", int'(core_q), int'(q_bank[esel]));
      chk("core_start", int'(core_start), int'(c_start));
      chk("result_valid", int'(result_valid), int'(c_rv));
      chk("batch_done", int'(batch_done), int'(c_bd));
      chk("busy", int'(busy), int'(c_busy));
      chk("sel", int'(sel), esel);
      chk("pass_cnt", int'(pass_cnt), npass);
      chk("fail_cnt", int'(fail_cnt), nfail);
      chk("timeout_err", int'(timeout_err), int'(to_e));
      if (c_rv) begin
        chk("result_pass", int'(result_pass), int'(e_pass));
        res_log.push_back(result_pass);
        sel_log.push_back(int'(sel));
      end
      n_start = 0;
      n_rv    = 0;
      n_bd    = 0;
      if (rst) begin
        active = 0; stop_l = 0; to_e = 0;
        esel = 0; npass = 0; nfail = 0;
      end else if (!active) begin
        if (go) begin
          active = 1; loop_l = loop_mode; stop_l = 0;
          to_e = 0; esel = 0; npass = 0; nfail = 0;
          nres = 0; n_start = 1;
        end
      end else begin
        if (stop_req) stop_l = 1;
        if (c_bd) begin
          active = 0;
          stop_l = 0;
        end else if (c_rv) begin
          nres++;
          if (e_pass) begin
            if (npass < CMAX) npass++;
          end else begin
            if (nfail < CMAX) nfail++;
          end
          if (stop_l || (esel == N - 1 && !loop_l)) begin
            n_bd = 1;
          end else begin
            esel = (esel + 1) % N;
            n_start = 1;
          end
        end else if (c_start) begin
          wcnt = 1;
        end else begin
          if (core_done) begin
            n_rv = 1;
            e_pass = (core_digit == label_tab[esel]);
          end else if (wcnt == TO - 1) begin
            n_bd = 1;
            to_e = 1;
          end else begin
            wcnt++;
          end
        end
      end
      c_busy  = active;
      c_start = n_start;
      c_rv    = n_rv;
      c_bd    = n_bd;
    end
  end

  task automatic pulse_go(input bit lm);
    @(posedge clk);
    #1;
    go = 1'b1;
    loop_mode = lm;
    @(posedge clk);
    #1;
    go = 1'b0;
    loop_mode = 1'($urandom);
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1;
    stop_req = 1'b1;
    @(posedge clk);
    #1;
    stop_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!batch_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!batch_done) begin
      checks++;
      errors++;
      $display("FAIL batch_wait actual=expired required=batch_done");
    end
    @(posedge clk);
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (nres < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (nres < n) begin
      checks++;
      errors++;
      $display("FAIL result_wait actual=%0d required=%0d", nres, n);
    end
  endtask

  task automatic set_labels(input bit ident);
    for (int i = 0; i < N; i++) begin
      label_tab[i] = ident ? DW'(i) : DW'($urandom);
    end
  endtask

  initial begin
    int k;
    set_labels(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pass_cnt", int'(pass_cnt), 0);
    chk("rst_timeout", int'(timeout_err), 0);

    // one-shot, all pass, latencies near the timeout edge
    lat_lo = 55; lat_hi = 63;
    res_log.delete();
    pulse_go(0);
    wait_done(2000);
    chk("t1_pass_cnt", int'(pass_cnt), 10);
    chk("t1_fail_cnt", int'(fail_cnt), 0);
    chk("t1_sel", int'(sel), 9);
    chk("t1_results", res_log.size(), 10);

    // wrong digits on banks 3 and 7
    lat_lo = 1; lat_hi = 30;
    wrong_mask = 10'b0010001000;
    res_log.delete();
    pulse_go(0);
    wait_done(2000);
    chk("t2_pass_cnt", int'(pass_cnt), 8);
    chk("t2_fail_cnt", int'(fail_cnt), 2);
    chk("t2_res3", int'(res_log[3]), 0);
    chk("t2_res7", int'(res_log[7]), 0);
    chk("t2_res0", int'(res_log[0]), 1);

    // loop, stop during 13th sample, go while busy ignored
    wrong_mask = '0;
    lat_lo = 5; lat_hi = 20;
    sel_log.delete();
    pulse_go(1);
    wait_res(3, 1000);
    pulse_go(0);
    wait_res(12, 2000);
    pulse_stop();
    wait_done(500);
    chk("t3_results", sel_log.size(), 13);
    chk("t3_sel10", sel_log[10], 0);
    chk("t3_sel12", sel_log[12], 2);
    chk("t3_sel", int'(sel), 2);

    // core never answers
    hang = 1;
    res_log.delete();
    pulse_go(0);
    @(negedge clk);
    k = 0;
    while (!batch_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t4_to_latency", k, TO);
    chk("t4_timeout_err", int'(timeout_err), 1);
    chk("t4_results", res_log.size(), 0);
    chk("t4_pass_cnt", int'(pass_cnt), 0);
    @(posedge clk);
    hang = 0;

    // saturate pass counter in loop mode
    lat_lo = 1; lat_hi = 2;
    pulse_go(1);
    chk("t5_timeout_clr", int'(timeout_err), 0);
    wait_res(260, 4000);
    pulse_stop();
    wait_done(200);
    chk("t5_pass_sat", int'(pass_cnt), 255);
    chk("t5_fail_cnt", int'(fail_cnt), 0);

    // reset mid-WAIT, then restart
    lat_lo = 20; lat_hi = 30;
    pulse_go(0);
    wait_res(2, 1000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_sel", int'(sel), 0);
    chk("t6_pass_cnt", int'(pass_cnt), 0);
    chk("t6_busy", int'(busy), 0);
    repeat (40) @(posedge clk);
    pulse_go(0);
    @(negedge clk);
    chk("t6_go2start", int'(core_start), 1);
    wait_done(1000);

    // random batches
    for (int b = 0; b < 4; b++) begin
      bit lm;
      set_labels(0);
      wrong_mask = N'($urandom);
      lat_lo = 1; lat_hi = 63;
      lm = 1'($urandom);
      pulse_go(lm);
      if (lm) begin
        wait_res($urandom_range(25, 1), 3000);
        pulse_stop();
      end
      wait_done(3000);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_batch_sequencer.md
Name: snn_batch_sequencer

Overview:
Synthesizable batch controller for snn_core. It steps through NUM_SAMPLES input-sample RAM banks and muxes the selected bank's 1-bit q onto the core's q_input. For each bank it pulses the core start, waits for done, and compares the returned digit against a per-sample expected label. It keeps pass, fail and timeout statistics, supports one-shot and continuous-loop modes, and replaces the simulation-only sample sweep with on-chip self-test hardware.

Parameters:
NUM_SAMPLES, 10, number of input sample banks (>=2)
SEL_W, $clog2(NUM_SAMPLES), bank select width (derived; not overridden)
ADDR_WIDTH, 10, input RAM address width (784 pixels fit in 1024)
DIGIT_WIDTH, 4, classifier result width
TIMEOUT_CYCLES, 65536, max cycles from core_start to core_done
CNT_WIDTH, 8, statistics counter width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
go  in  1  one-cycle pulse; begins a batch when idle
loop_mode  in  1  sampled at go; 1 = restart at bank 0 after the last bank
stop_req  in  1  pulse; finish the current sample, then end the batch
exp_label  in  DIGIT_WIDTH  expected digit for bank sel (combinational lookup outside)
q_bank  in  NUM_SAMPLES  q outputs of all input RAMs
core_addr  in  ADDR_WIDTH  addr_input_unit from snn_core
ram_addr  out  ADDR_WIDTH  broadcast address to all input RAMs (= core_addr)
core_q  out  1  q_bank[sel] to snn_core q_input
core_start  out  1  start pulse to snn_core
core_done  in  1  done from snn_core
core_digit  in  DIGIT_WIDTH  digit from snn_core
sel  out  SEL_W  current bank index
busy  out  1  high whenever state != IDLE
result_valid  out  1  one-cycle pulse per classified sample
result_pass  out  1  comparison result; qualified by result_valid
pass_cnt  out  CNT_WIDTH  saturating count of passes
fail_cnt  out  CNT_WIDTH  saturating count of mismatches
timeout_err  out  1  sticky flag; batch aborted on timeout
batch_done  out  1  one-cycle pulse when the batch ends

Behaviour:
- Reset: state IDLE; sel=0; pass_cnt, fail_cnt=0; timeout_err=0; core_start, result_valid, result_pass, batch_done, busy=0.
- ram_addr=core_addr and core_q=q_bank[sel] are combinational. sel changes only when the core is idle.
- IDLE: go -> START. On go: clear the counters and timeout_err, set sel=0, latch loop_mode. go is ignored when not in IDLE.
- START: core_start=1 for exactly one cycle; clear the timeout counter; -> WAIT.
- WAIT: increment the timeout counter each cycle.
  - core_done sampled high -> CHECK, with core_digit registered into the result register.
  - Counter reaches TIMEOUT_CYCLES-1 without done -> set timeout_err, -> FINISH. No result pulse.
- CHECK (1 cycle): result_pass = (digit_reg == exp_label); result_valid=1; increment pass_cnt or fail_cnt, saturating at all-ones.
  - If stop_pending or (sel==NUM_SAMPLES-1 and !loop latched): -> FINISH.
  - Otherwise: sel = (sel==NUM_SAMPLES-1) ? 0 : sel+1; -> START.
- FINISH: batch_done=1 for one cycle; -> IDLE. sel holds its last value.
- stop_req in any non-IDLE state sets stop_pending, which is cleared on entering IDLE. stop_req in IDLE is ignored.
- Latency: go to first core_start = 1 cycle. core_done to result_valid = 1 cycle. result_valid to next core_start = 1 cycle.
- Simultaneous events:
  - stop_req with core_done: the current result is recorded, then FINISH.
  - core_done on the same cycle the timeout is reached: done wins.
- rst mid-batch returns all state to reset values on the next edge. No core_start is issued.
- Done level vs edge: core_done is treated as level. WAIT is only entered after START, so a stale done from the previous sample cannot be re-counted, because the CHECK->START->WAIT path takes 2 cycles. The core must drop done within 1 cycle of start.

Decomposition:
- Package snn_seq_pkg holds:
  - state enum seq_state_t {IDLE, START, WAIT, CHECK, FINISH};
  - the saturating-increment function.
- Sub-module sat_counter (parametrised width, synchronous clear, enable, saturate). Instantiate it for pass_cnt and fail_cnt.

Test Plan:
- Behavioural core model returns digit=sel after 100 cycles; exp_label=sel; NUM_SAMPLES=10, one-shot -> 10 result_valid pulses all with pass; pass_cnt=10, fail_cnt=0; batch_done 1 cycle after the 10th CHECK; sel=9.
- Model returns wrong digit for sel=3 and sel=7 -> pass_cnt=8, fail_cnt=2; result_pass=0 on the 4th and 8th pulses.
- loop_mode=1; stop_req asserted during the 13th sample (sel=2) -> 13 results; sel sequence 0..9,0,1,2; then batch_done.
- Model never asserts done; TIMEOUT_CYCLES=64 -> timeout_err=1, batch_done 64 cycles after core_start, counters 0, no result_valid.
- CNT_WIDTH=3, loop 12 passing samples then stop -> pass_cnt saturates at 7.
- rst asserted mid-WAIT, then go -> counters cleared, sel=0, a fresh core_start 1 cycle after go. Also: go while busy -> no effect; core_q tracks q_bank[sel] at every core_addr.
